// File: rtl/ccff_loader.sv
// ccff_loader
//   Configuration-chain loader placed directly upstream of a tile's ccff_head.
//   It accepts bitstream words on a valid/ready interface. Each word is
//   serialised MSB-first into the configuration flip-flop chain, one bit per
//   enabled prog_clk edge.
//   In verify mode it counts the edges where the bit emerging from ccff_tail
//   differs from the bit being shifted in. A second identical load therefore
//   checks the first.
//
// Ports
//   prog_clk        programming clock, all state on the rising edge
//   reset           asynchronous reset, active low
//   start           request a load (honoured in IDLE or DONE)
//   verify          sampled with start; enables tail mismatch counting
//   abort           synchronous abort back to IDLE
//   cfg_data        bitstream word, bit WORD_W-1 shifted first
//   cfg_valid       cfg_data valid
//   cfg_ready       loader takes cfg_data this cycle
//   ccff_head       registered serial bit to the chain
//   prog_clk_en     registered shift enable for the chain's prog_clk gate
//   ccff_tail       serial output of the chain's last flip-flop
//   busy            high while loading or draining
//   done            sticky completion flag
//   bit_count       enabled shift edges completed in this/last load
//   mismatch_count  saturating verify mismatch count

module ccff_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 32,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1),
  parameter int ERR_W     = 16
) (
  input  logic              prog_clk,
  input  logic              reset,
  input  logic              start,
  input  logic              verify,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              prog_clk_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_count,
  output logic [ERR_W-1:0]  mismatch_count
);

  // Words per load, and how many bits of the final word are actually used.
  localparam int NW        = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int LAST_BITS = CHAIN_LEN - (NW - 1) * WORD_W;
  localparam int BL_W      = $clog2(WORD_W + 1);
  localparam int WA_W      = $clog2(NW + 1);

  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [WA_W-1:0]  WORDS_MAX = WA_W'(NW);
  localparam logic [WA_W-1:0]  WORD_LAST = WA_W'(NW - 1);
  localparam logic [BL_W-1:0]  FULL_BITS = BL_W'(WORD_W);
  localparam logic [BL_W-1:0]  TAIL_BITS = BL_W'(LAST_BITS);
  localparam logic [BL_W-1:0]  ONE_BIT   = BL_W'(1);
  localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t            state;
  state_t            next_state;
  logic [WORD_W-1:0] buf_data;
  logic [BL_W-1:0]   buf_left;
  logic [WA_W-1:0]   words_acc;
  logic [CNT_W-1:0]  issue_cnt;
  logic              verify_q;
  logic              start_ok;
  logic              issuing;
  logic              transfer;

  // abort outranks start and cfg transfers, so both are masked by it here.
  // The buffer is refilled while it issues its last bit, which keeps the
  // shift stream free of bubbles across word boundaries.
  assign start_ok  = start & ~abort & ((state == IDLE) | (state == DONE));
  assign issuing   = (state == LOAD) & (buf_left != '0) & ~abort;
  assign cfg_ready = (state == LOAD) & (words_acc < WORDS_MAX) &
                     ((buf_left == '0) | (buf_left == ONE_BIT)) & ~abort;
  assign transfer  = cfg_valid & cfg_ready;
  assign busy      = (state == LOAD) | (state == DRAIN);
  assign done      = (state == DONE);

  always_ff @(posedge prog_clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // LOAD ends once the last bit has been issued; DRAIN ends on the edge
  // where the chain actually consumes that bit.
  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (start) next_state = LOAD;
        LOAD:       if (issuing && issue_cnt == LAST_IDX) next_state = DRAIN;
        DRAIN:      if (prog_clk_en && bit_count == LAST_IDX) next_state = DONE;
        default:    next_state = IDLE;
      endcase
    end
  end

  // An abort leaves the counters frozen and drops the enable immediately.
  // Counting follows the registered enable, i.e. the edges the chain shifts on.
  always_ff @(posedge prog_clk or negedge reset) begin
    if (!reset) begin
      buf_data       <= '0;
      buf_left       <= '0;
      words_acc      <= '0;
      issue_cnt      <= '0;
      verify_q       <= 1'b0;
      ccff_head      <= 1'b0;
      prog_clk_en    <= 1'b0;
      bit_count      <= '0;
      mismatch_count <= '0;
    end else if (abort) begin
      prog_clk_en <= 1'b0;
      buf_left    <= '0;
      words_acc   <= '0;
    end else if (start_ok) begin
      bit_count      <= '0;
      mismatch_count <= '0;
      verify_q       <= verify;
      issue_cnt      <= '0;
      words_acc      <= '0;
      buf_left       <= '0;
      prog_clk_en    <= 1'b0;
    end else begin
      if (prog_clk_en) begin
        bit_count <= bit_count + CNT_W'(1);
        if (verify_q && (ccff_tail != ccff_head) && (mismatch_count != ERR_MAX))
          mismatch_count <= mismatch_count + ERR_W'(1);
      end
      prog_clk_en <= issuing;
      if (issuing) begin
        ccff_head <= buf_data[WORD_W-1];
        buf_data  <= buf_data << 1;
        buf_left  <= buf_left - ONE_BIT;
        issue_cnt <= issue_cnt + CNT_W'(1);
      end
      if (transfer) begin
        buf_data  <= cfg_data;
        buf_left  <= (words_acc == WORD_LAST) ? TAIL_BITS : FULL_BITS;
        words_acc <= words_acc + WA_W'(1);
      end
    end
  end

endmodule
